// File: rtl/seq_pkg.sv
// Shared definitions for the sequence framing blocks: FSM state encoding,
// the default sync pattern, and a counter-width helper.
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SYNC = 2'b01,
      DATA = 2'b10,
      PAR  = 2'b11
   } state_e;

   // Default sync word; the 1001 detector keys on the same constant.
   localparam logic [3:0] SYNC_PAT_DEF = 4'b1001;

   // Down-counter width able to index the longer of the sync and payload fields.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/seq_piso_shreg.sv
// Parallel-in serial-out shift register, MSB first, with a running even-parity
// accumulator over the bits already shifted out.
module seq_piso_shreg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic         shift_i,
   input  logic [W-1:0] data_i,
   output logic         msb_o,
   output logic         parity_o
);

   logic [W-1:0] sh_q, sh_d;
   logic         par_q, par_d;

   // Load clears the parity; each shift folds the outgoing MSB into it.
   always_comb begin
      sh_d  = sh_q;
      par_d = par_q;
      if (load_i) begin
         sh_d  = data_i;
         par_d = 1'b0;
      end else if (shift_i) begin
         sh_d  = sh_q << 1;
         par_d = par_q ^ sh_q[W-1];
      end
   end

   // Shift register and parity state.
   always_ff @(posedge clk) begin
      if (rst) begin
         sh_q  <= '0;
         par_q <= 1'b0;
      end else begin
         sh_q  <= sh_d;
         par_q <= par_d;
      end
   end

   assign msb_o    = sh_q[W-1];
   assign parity_o = par_q;

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync pattern, payload MSB first, optional even
// parity. Line outputs are registered from the next-state values so each
// output bit lines up with the state that owns it.
module seq_frame_tx
   import seq_pkg::*;
#(
   parameter int                DATA_W    = 8,
   parameter int                SYNC_W    = 4,
   parameter logic [SYNC_W-1:0] SYNC_PAT  = SYNC_W'(SYNC_PAT_DEF),
   parameter int                PARITY_EN = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              op,
   output logic              op_valid,
   output logic              busy,
   output logic              frame_done
);

   localparam int CNT_W = cnt_width(SYNC_W, DATA_W);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               op_q, op_d;
   logic               op_valid_q, busy_q, busy_d;
   logic               frame_done_q, frame_done_d;
   logic [SYNC_W-1:0]  sync_sh;
   logic               load, shift, sh_msb, sh_par;

   // Next state and bit counter; the counter reloads on every state entry
   // and counts down to zero, so it never runs past a field.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (din_valid) begin
               state_d = SYNC;
               cnt_d   = CNT_W'(SYNC_W - 1);
            end
         end
         SYNC: begin
            if (cnt_q == '0) begin
               state_d = DATA;
               cnt_d   = CNT_W'(DATA_W - 1);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DATA: begin
            if (cnt_q == '0) begin
               state_d = (PARITY_EN != 0) ? PAR : IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         PAR: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Output bit for the state being entered; IDLE parks the line at 0.
   always_comb begin
      sync_sh      = SYNC_PAT >> cnt_d;
      op_d         = 1'b0;
      case (state_d)
         SYNC:    op_d = sync_sh[0];
         DATA:    op_d = sh_msb;
         PAR:     op_d = sh_par;
         default: op_d = 1'b0;
      endcase
      busy_d       = (state_d != IDLE);
      frame_done_d = (PARITY_EN != 0) ? (state_d == PAR)
                                      : ((state_d == DATA) && (cnt_d == '0));
   end

   // Payload is captured on the handshake and shifted as each data bit goes out.
   assign load  = (state_q == IDLE) && din_valid;
   assign shift = (state_d == DATA);

   seq_piso_shreg #(.W(DATA_W)) u_shreg (
      .clk      (clk),
      .rst      (rst),
      .load_i   (load),
      .shift_i  (shift),
      .data_i   (din),
      .msb_o    (sh_msb),
      .parity_o (sh_par)
   );

   // State, counter and registered line outputs; reset aborts any frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         op_q         <= 1'b0;
         op_valid_q   <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         op_q         <= op_d;
         op_valid_q   <= busy_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign din_ready  = (state_q == IDLE) && !rst;
   assign op         = op_q;
   assign op_valid   = op_valid_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule
